// File: rtl/pht_sat_ctr_table_if.sv
// rtl/pht_sat_ctr_table_if.sv - predict/update port bundle for the pattern history table
interface pht_sat_ctr_table_if #(
    parameter int CTR_WIDTH = 2,
    parameter int IDX_WIDTH = 6,
    parameter int PC_WIDTH  = 32
);
    logic                 pred_req;
    logic [PC_WIDTH-1:0]  pred_pc;
    logic                 pred_vld;
    logic                 pred_taken;
    logic [CTR_WIDTH-1:0] pred_ctr;
    logic [IDX_WIDTH-1:0] pred_idx;
    logic                 upd_vld;
    logic [IDX_WIDTH-1:0] upd_idx;
    logic                 upd_taken;
    logic                 ready;

    modport master (
        output pred_req, pred_pc, upd_vld, upd_idx, upd_taken,
        input  pred_vld, pred_taken, pred_ctr, pred_idx, ready
    );

    modport slave (
        input  pred_req, pred_pc, upd_vld, upd_idx, upd_taken,
        output pred_vld, pred_taken, pred_ctr, pred_idx, ready
    );
endinterface

// File: rtl/pht_sat_ctr_table.sv
// rtl/pht_sat_ctr_table.sv - pattern history table of saturating counters with bimodal/gshare indexing
module pht_sat_ctr_table #(
    parameter int CTR_WIDTH = 2,
    parameter int IDX_WIDTH = 6,
    parameter int HIST_LEN  = 6,
    parameter int MODE      = 1,
    parameter int PC_WIDTH  = 32
) (
    input  logic clk,
    input  logic reset,
    pht_sat_ctr_table_if.slave bus
);
    localparam int DEPTH = 1 << IDX_WIDTH;
    localparam logic [CTR_WIDTH-1:0] INIT_VAL = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               state;
    logic [IDX_WIDTH-1:0] ptr;
    logic [HIST_LEN-1:0]  ghr;
    logic [HIST_LEN-1:0]  ghr_next;
    logic [CTR_WIDTH-1:0] table_q [DEPTH];

    logic [IDX_WIDTH-1:0] hist_idx;
    logic [IDX_WIDTH-1:0] idx;
    logic [CTR_WIDTH-1:0] upd_cur;
    logic [CTR_WIDTH-1:0] upd_next;
    logic [CTR_WIDTH-1:0] rd_val;
    logic                 wr_en;
    logic [IDX_WIDTH-1:0] wr_idx;
    logic [CTR_WIDTH-1:0] wr_val;

    logic                 ready_q;
    logic                 vld_q;
    logic                 taken_q;
    logic [CTR_WIDTH-1:0] ctr_q;
    logic [IDX_WIDTH-1:0] idx_q;

    // Only the index field of the PC feeds the table; the rest is deliberately ignored.
    logic unused_pc;
    assign unused_pc = ^{bus.pred_pc[PC_WIDTH-1:IDX_WIDTH+2], bus.pred_pc[1:0]};

    // History is folded into the index only in gshare mode; it still shifts in bimodal mode.
    assign hist_idx = (MODE != 0) ? IDX_WIDTH'(ghr) : '0;
    assign idx      = bus.pred_pc[IDX_WIDTH+1:2] ^ hist_idx;

    // A one-bit history simply holds the most recent outcome.
    generate
        if (HIST_LEN == 1) begin : g_hist_one
            assign ghr_next = bus.upd_taken;
        end else begin : g_hist_shift
            assign ghr_next = {ghr[HIST_LEN-2:0], bus.upd_taken};
        end
    endgenerate

    // Saturating next value of the entry being trained, and the bypassed read value.
    always_comb begin
        upd_cur  = table_q[bus.upd_idx];
        upd_next = upd_cur;
        if (bus.upd_taken) begin
            if (!(&upd_cur)) upd_next = upd_cur + CTR_WIDTH'(1);
        end else begin
            if (|upd_cur) upd_next = upd_cur - CTR_WIDTH'(1);
        end
        rd_val = (bus.upd_vld && (bus.upd_idx == idx)) ? upd_next : table_q[idx];
    end

    // Single write port: init sweep owns it during INIT, branch resolution during RUN.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = ptr;
        wr_val = INIT_VAL;
        if (state == ST_INIT) begin
            wr_en = 1'b1;
        end else if (bus.upd_vld) begin
            wr_en  = 1'b1;
            wr_idx = bus.upd_idx;
            wr_val = upd_next;
        end
    end

    // Counter storage; contents are meaningless until the sweep has covered every entry.
    always_ff @(posedge clk) begin
        if (wr_en) table_q[wr_idx] <= wr_val;
    end

    // Control FSM, history register and registered prediction outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_INIT;
            ptr     <= '0;
            ghr     <= '0;
            ready_q <= 1'b0;
            vld_q   <= 1'b0;
            taken_q <= 1'b0;
            ctr_q   <= '0;
            idx_q   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    vld_q <= 1'b0;
                    ptr   <= ptr + 1'b1;
                    if (&ptr) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    vld_q <= bus.pred_req;
                    if (bus.pred_req) begin
                        idx_q   <= idx;
                        ctr_q   <= rd_val;
                        taken_q <= rd_val[CTR_WIDTH-1];
                    end
                    if (bus.upd_vld) ghr <= ghr_next;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.pred_vld   = vld_q;
    assign bus.pred_taken = taken_q;
    assign bus.pred_ctr   = ctr_q;
    assign bus.pred_idx   = idx_q;
endmodule

// File: tb/tb_pht_sat_ctr_table.sv
// tb/tb_pht_sat_ctr_table.sv - scoreboard bench for bimodal, gshare and 3-bit table instances
module tb_pht_sat_ctr_table;
    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        req   = 1'b0;
    logic [31:0] pc_s  = '0;
    logic        uv    = 1'b0;
    logic [5:0]  ui    = '0;
    logic        ut    = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;

    int         m_tbl [3][64];
    logic [5:0] m_ghr [3];
    int         init_cnt;
    int         q0[$];
    int         q1[$];
    int         q2[$];

    always #5 clk = ~clk;

    pht_sat_ctr_table_if #(.CTR_WIDTH(2), .IDX_WIDTH(6), .PC_WIDTH(32)) ifa ();
    pht_sat_ctr_table_if #(.CTR_WIDTH(2), .IDX_WIDTH(6), .PC_WIDTH(32)) ifb ();
    pht_sat_ctr_table_if #(.CTR_WIDTH(3), .IDX_WIDTH(6), .PC_WIDTH(32)) ifc ();

    assign ifa.pred_req = req;  assign ifa.pred_pc = pc_s;  assign ifa.upd_vld = uv;
    assign ifa.upd_idx  = ui;   assign ifa.upd_taken = ut;
    assign ifb.pred_req = req;  assign ifb.pred_pc = pc_s;  assign ifb.upd_vld = uv;
    assign ifb.upd_idx  = ui;   assign ifb.upd_taken = ut;
    assign ifc.pred_req = req;  assign ifc.pred_pc = pc_s;  assign ifc.upd_vld = uv;
    assign ifc.upd_idx  = ui;   assign ifc.upd_taken = ut;

    pht_sat_ctr_table #(.CTR_WIDTH(2), .IDX_WIDTH(6), .HIST_LEN(6), .MODE(0), .PC_WIDTH(32))
        u_bim (.clk(clk), .reset(reset), .bus(ifa));
    pht_sat_ctr_table #(.CTR_WIDTH(2), .IDX_WIDTH(6), .HIST_LEN(6), .MODE(1), .PC_WIDTH(32))
        u_gsh (.clk(clk), .reset(reset), .bus(ifb));
    pht_sat_ctr_table #(.CTR_WIDTH(3), .IDX_WIDTH(6), .HIST_LEN(6), .MODE(0), .PC_WIDTH(32))
        u_w3 (.clk(clk), .reset(reset), .bus(ifc));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cw(input int k);
        return (k == 2) ? 3 : 2;
    endfunction

    function automatic bit md(input int k);
        return (k == 1);
    endfunction

    task automatic push(input int k, input int v);
        case (k)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic pop(input int k, output int v, output bit ok);
        v  = 0;
        ok = 1'b0;
        case (k)
            0: if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic sample(input int k, output logic vld, output int idx, output int ctr,
                          output logic tk, output logic rdy);
        case (k)
            0: begin vld = ifa.pred_vld; idx = int'(ifa.pred_idx); ctr = int'(ifa.pred_ctr);
                     tk = ifa.pred_taken; rdy = ifa.ready; end
            1: begin vld = ifb.pred_vld; idx = int'(ifb.pred_idx); ctr = int'(ifb.pred_ctr);
                     tk = ifb.pred_taken; rdy = ifb.ready; end
            default: begin vld = ifc.pred_vld; idx = int'(ifc.pred_idx); ctr = int'(ifc.pred_ctr);
                     tk = ifc.pred_taken; rdy = ifc.ready; end
        endcase
    endtask

    task automatic model_reset();
        init_cnt = 0;
        q0.delete();
        q1.delete();
        q2.delete();
        for (int k = 0; k < 3; k++) begin
            m_ghr[k] = '0;
            for (int e = 0; e < 64; e++) m_tbl[k][e] = (1 << (cw(k) - 1)) - 1;
        end
    endtask

    // One clock of stimulus: model computes expectations, DUT outputs checked after the edge.
    task automatic step(input logic a_rq, input logic [31:0] a_pc, input logic a_uv,
                        input logic [5:0] a_ui, input logic a_ut);
        int   idx, nv, pv, v, maxv, sidx, sctr;
        bit   ok;
        logic exp_vld [3];
        logic vld, tk, rdy;
        logic [5:0] pcidx;
        @(negedge clk);
        req = a_rq; pc_s = a_pc; uv = a_uv; ui = a_ui; ut = a_ut;
        pcidx = a_pc[7:2];
        for (int k = 0; k < 3; k++) begin
            exp_vld[k] = 1'b0;
            if (init_cnt >= 64) begin
                maxv = (1 << cw(k)) - 1;
                idx  = int'(pcidx ^ (md(k) ? m_ghr[k] : 6'd0));
                nv   = m_tbl[k][a_ui];
                if (a_uv) nv = a_ut ? ((nv == maxv) ? nv : nv + 1) : ((nv == 0) ? 0 : nv - 1);
                if (a_rq) begin
                    pv = (a_uv && idx == int'(a_ui)) ? nv : m_tbl[k][idx];
                    push(k, idx * 16 + pv);
                    exp_vld[k] = 1'b1;
                end
                if (a_uv) begin
                    m_tbl[k][a_ui] = nv;
                    m_ghr[k] = {m_ghr[k][4:0], a_ut};
                end
            end
        end
        @(posedge clk);
        #1;
        if (init_cnt < 64) init_cnt++;
        for (int k = 0; k < 3; k++) begin
            sample(k, vld, sidx, sctr, tk, rdy);
            check_eq($sformatf("vld[%0d]", k), vld, exp_vld[k]);
            check_eq($sformatf("ready[%0d]", k), rdy, (init_cnt >= 64));
            if (vld === 1'b1) begin
                pop(k, v, ok);
                check_eq($sformatf("sb_pop[%0d]", k), ok, 1);
                if (ok) begin
                    check_eq($sformatf("idx[%0d]", k), sidx, v / 16);
                    check_eq($sformatf("ctr[%0d]", k), sctr, v % 16);
                    check_eq($sformatf("taken[%0d]", k), tk, ((v % 16) >> (cw(k) - 1)) & 1);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic vld, tk, rdy;
        int   sidx, sctr;
        for (int k = 0; k < 3; k++) begin
            sample(k, vld, sidx, sctr, tk, rdy);
            check_eq($sformatf("%s_vld[%0d]", tag, k), vld, 0);
            check_eq($sformatf("%s_ready[%0d]", tag, k), rdy, 0);
            check_eq($sformatf("%s_ctr[%0d]", tag, k), sctr, 0);
            check_eq($sformatf("%s_idx[%0d]", tag, k), sidx, 0);
            check_eq($sformatf("%s_taken[%0d]", tag, k), tk, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic vld, tk, rdy;
        int   sidx, sctr;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");

        @(posedge clk);
        #1;
        reset = 1'b1;

        // Init sweep: requests and updates must be ignored, ready rises after exactly 64 cycles.
        repeat (64) step(1'b1, $urandom, 1'b1, 6'($urandom), 1'($urandom));

        // First predictions after init see the weakly-not-taken value.
        step(1'b1, 32'h0000_0000, 1'b0, 6'd0, 1'b0);
        step(1'b1, 32'h0000_0040, 1'b0, 6'd0, 1'b0);

        // Saturation upward with bypass observation, then downward with no wrap.
        repeat (4) step(1'b1, 32'h0000_0100, 1'b1, 6'd0, 1'b1);
        step(1'b1, 32'h0000_0100, 1'b0, 6'd0, 1'b0);
        sample(0, vld, sidx, sctr, tk, rdy);
        check_eq("sat_hi_ctr", sctr, 3);
        check_eq("sat_hi_taken", tk, 1);
        repeat (5) step(1'b1, 32'h0000_0100, 1'b1, 6'd0, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b0, 6'd0, 1'b0);
        sample(0, vld, sidx, sctr, tk, rdy);
        check_eq("sat_lo_ctr", sctr, 0);

        // Bypass on matching index, independence on differing index.
        step(1'b1, 32'h0000_0014, 1'b1, 6'd5, 1'b1);
        sample(0, vld, sidx, sctr, tk, rdy);
        check_eq("byp_ctr", sctr, 2);
        check_eq("byp_taken", tk, 1);
        step(1'b1, 32'h0000_0024, 1'b1, 6'd10, 1'b1);
        sample(0, vld, sidx, sctr, tk, rdy);
        check_eq("nobyp_ctr", sctr, 1);

        // Gshare: flush history with not-taken, then T,T,N gives GHR=000110.
        repeat (6) step(1'b0, 32'h0, 1'b1, 6'd30, 1'b0);
        step(1'b0, 32'h0, 1'b1, 6'd20, 1'b1);
        step(1'b0, 32'h0, 1'b1, 6'd20, 1'b1);
        step(1'b0, 32'h0, 1'b1, 6'd20, 1'b0);
        step(1'b1, 32'h0000_0040, 1'b0, 6'd0, 1'b0);
        sample(1, vld, sidx, sctr, tk, rdy);
        check_eq("gshare_idx", sidx, 22);
        sample(0, vld, sidx, sctr, tk, rdy);
        check_eq("bimodal_idx", sidx, 16);

        // Width generality on entry 40 of the 3-bit instance.
        step(1'b1, 32'h0000_00A0, 1'b1, 6'd40, 1'b1);
        sample(2, vld, sidx, sctr, tk, rdy);
        check_eq("w3_first_ctr", sctr, 4);
        check_eq("w3_first_taken", tk, 1);
        repeat (8) step(1'b0, 32'h0, 1'b1, 6'd40, 1'b1);
        step(1'b1, 32'h0000_00A0, 1'b0, 6'd0, 1'b0);
        sample(2, vld, sidx, sctr, tk, rdy);
        check_eq("w3_sat_ctr", sctr, 7);

        // Random mix of predictions and updates.
        repeat (200) step(1'($urandom), $urandom, 1'($urandom), 6'($urandom_range(0, 7)), 1'($urandom));

        // Train entry 0 to strongly taken, then reset asynchronously between edges.
        repeat (3) step(1'b0, 32'h0, 1'b1, 6'd0, 1'b1);
        step(1'b1, 32'h0000_0000, 1'b0, 6'd0, 1'b0);
        #2;
        reset = 1'b0;
        req   = 1'b0;
        uv    = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (64) step(1'b1, $urandom, 1'b1, 6'($urandom), 1'b1);
        step(1'b1, 32'h0000_0100, 1'b0, 6'd0, 1'b0);
        sample(0, vld, sidx, sctr, tk, rdy);
        check_eq("resweep_ctr", sctr, 1);
        check_eq("resweep_taken", tk, 0);

        step(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/pht_sat_ctr_table.md
Name: pht_sat_ctr_table

Overview:
Parametrised pattern history table of N-bit saturating counters, generalising the 4-state taken/not-taken FSM to a table of DEPTH counters of configurable width. It supports bimodal or gshare indexing, a 1-cycle registered prediction port, an update port with same-cycle bypass, and a post-reset initialisation sweep. It sits between fetch (predict) and branch resolution (update) in the branch predictor.

Parameters:
CTR_WIDTH, 2, counter bits per entry (>=1); taken when counter MSB = 1.
IDX_WIDTH, 6, table index bits; DEPTH = 2**IDX_WIDTH entries.
HIST_LEN, 6, global history register length (1..IDX_WIDTH).
MODE, 1, 0 = bimodal (index = PC bits), 1 = gshare (PC bits XOR history).
PC_WIDTH, 32, PC width (>= IDX_WIDTH+2).

Ports:
clk  in  1  clock; all state rises on posedge.
reset  in  1  asynchronous, active-low reset.
pred_req  in  1  prediction request this cycle.
pred_pc  in  PC_WIDTH  branch PC; index source is pred_pc[IDX_WIDTH+1:2].
pred_vld  out  1  registered: prediction result valid.
pred_taken  out  1  registered: MSB of counter read.
pred_ctr  out  CTR_WIDTH  registered: counter value read.
pred_idx  out  IDX_WIDTH  registered: index used; carried down pipe for update.
upd_vld  in  1  branch resolved this cycle.
upd_idx  in  IDX_WIDTH  entry to update (the pred_idx returned).
upd_taken  in  1  resolved direction.
ready  out  1  1 = table initialised, accepting requests.

Behaviour:
- INIT_VAL = 2**(CTR_WIDTH-1)-1 (weakly not-taken; 2'b01 for CTR_WIDTH=2). MAX = 2**CTR_WIDTH-1.
- reset low (async): ready=0, pred_vld=0, pred_taken=0, pred_ctr=0, pred_idx=0, GHR=0, sweep pointer=0, FSM=INIT. Table contents undefined until the sweep completes.
- FSM INIT: once reset deasserts, writes INIT_VAL to entry[ptr] each cycle and increments ptr. When ptr = DEPTH-1 has been written, moves to RUN the next cycle; ready=1 from the first RUN cycle. The sweep takes exactly DEPTH cycles.
- During INIT: pred_req and upd_vld are ignored (no table write, no GHR shift), and pred_vld stays 0.
- RUN, index: idx = pred_pc[IDX_WIDTH+1:2] XOR (MODE ? zero-extended GHR[HIST_LEN-1:0] : 0). GHR is sampled before any same-cycle shift.
- RUN, predict: if pred_req, then on the next clk pred_vld=1, pred_idx=idx, pred_ctr=entry value, pred_taken=pred_ctr[MSB]. If not pred_req, pred_vld=0 next cycle and the other outputs hold their last values. Latency is exactly 1 cycle; one request per cycle, no backpressure.
- RUN, update: if upd_vld, then on the clk edge:
  - upd_taken=1: entry = min(entry+1, MAX).
  - upd_taken=0: entry = max(entry-1, 0).
  - No wrap-around at either end.
  - GHR = {GHR[HIST_LEN-2:0], upd_taken} (HIST_LEN=1: GHR = upd_taken). The GHR shifts in both MODEs but is used only when MODE=1.
- Bypass: if pred_req and upd_vld are in the same cycle and idx == upd_idx, the registered pred_ctr/pred_taken are the post-update (saturated) value. Different indices behave independently.
- reset asserted mid-RUN: all outputs return to reset values immediately and the full sweep reruns, so prior training is lost.
- Table is a register array (no SRAM); write port 1, read port 1.

Test Plan:
- Reset/init (CTR_WIDTH=2, IDX_WIDTH=6): release reset -> ready=0 for exactly 64 cycles, then 1. A pred_req during init -> pred_vld stays 0. First predict of any PC -> pred_ctr=2'b01, pred_taken=0.
- Saturation (MODE=0): pc=0x100 (idx 0) gets 4x upd taken -> ctr sequence 01,10,11,11; predict -> taken=1, ctr=3. Then 5x not-taken -> 10,01,00,00,00; predict -> ctr=0, no wrap.
- Bypass: entry at 01, same cycle pred_req pc->idx 5 and upd_vld idx 5 taken -> next cycle pred_ctr=2'b10, pred_taken=1. With upd idx 6 instead -> pred_ctr=01.
- Gshare (MODE=1, HIST_LEN=6): updates taken,taken,not-taken -> GHR=6'b000110. pred_pc=0x40 (bits=16) -> pred_idx=16^6=22. Same stimulus with MODE=0 -> pred_idx=16.
- Width generality (CTR_WIDTH=3): init ctr=3. One taken update -> 4, taken=1. Eight more taken updates -> 7 (saturated).
- Async reset mid-run: after training entry 0 to 3, drop reset between clock edges -> pred_vld and ready go 0 immediately. Re-sweep, then entry 0 predicts 01.
